cp0: RTL and testbench
======================

# cp0

Coprocessor-0 for the five-stage MIPS32 pipeline: the consumer end of the per-stage exception flags (overflow, address errors, reserved instruction) that are pipelined down to the M stage.
- Holds SR, Cause, EPC and PRId.
- Arbitrates external hardware interrupts against M-stage exceptions.
- Raises a single flush/redirect request.
- Serves `mtc0`, `mfc0` and `eret`.
- Sits beside the M stage; the controller uses `req` to flush all stages and load `HANDLER_PC`.

## Interface
- `PRID_VALUE`, default 32'h0000_2019: read-only PRId contents.
- `HANDLER_PC`, default 32'h0000_4180: exception vector. Exported for the PC mux; not used internally.
- `clk` in 1: single clock, all state on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pc_m` in 32: PC of the M-stage instruction.
- `bd_m` in 1: the M-stage instruction sits in a branch delay slot.
- `exc_valid_m` in 1: the M-stage instruction carries an exception.
- `exc_code_m` in 5: ExcCode of that exception. Values: Ov=12, AdEL=4, AdES=5, RI=10.
- `hw_int` in 6: level-sensitive external interrupt lines.
- `cp0_we` in 1: `mtc0` in M.
- `cp0_addr` in 5: CP0 register index.
- `cp0_wdata` in 32: `mtc0` data.
- `cp0_rdata` out 32: `mfc0` data, combinational.
- `eret_m` in 1: `eret` in M.
- `req` out 1: take interrupt or exception this cycle, combinational.
- `epc` out 32: current EPC register, for `eret` redirect.

## Operation
- **SR (index 12)**
  - Fields: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Writable fields: IM, EXL, IE.
- **Cause (index 13)**
  - Fields: BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - Software writes are ignored.
- **EPC (index 14)**
  - Bits [31:2] are writable; [1:0] are always 0.
- **PRId (index 15):** reads `PRID_VALUE`.
- Any other index reads 0; writes to it are ignored.
- **Request logic**
  - `int_pend` = |(IP_next & IM) & IE & ~EXL, where IP_next = `hw_int`.
  - `exc_take` = `exc_valid_m` & ~EXL.
  - `req` = `int_pend` | `exc_take`.
- **Priority:** interrupt over exception. A simultaneous exception is discarded; it re-occurs when the flushed instruction re-executes.
- **On a rising edge with `req`=1**
  - EXL←1.
  - BD←`bd_m`.
  - ExcCode←(`int_pend` ? 0 : `exc_code_m`).
  - EPC←(`bd_m` ? `pc_m`−4 : `pc_m`) & ~3.
  - The `mtc0` in the same cycle is suppressed.
- **On a rising edge with `eret_m`=1 and `req`=0:** EXL←0.
- **`mtc0`:** updates the target register at the edge when `cp0_we`=1 and `req`=0.
  - When `eret_m` and an SR write coincide, `eret` wins for the EXL bit only.
- **IP:** IP←`hw_int` every edge, irrespective of EXL/IE.
- **Reset:** SR, Cause and EPC are cleared to 0; reset overrides every other event in the same cycle.
  - With IE=0, `req` is 0 out of reset for any `hw_int`.
  - `req`=`exc_valid_m` out of reset, since EXL=0.
- **Arithmetic:** `pc_m`−4 is a 32-bit modulo subtraction; wrap from 0 to 32'hFFFF_FFFC is accepted.

## Timing
- `req` and `cp0_rdata` are purely combinational from inputs and registered state; zero latency.
- State updates land one edge later.
  - An `mtc0` to SR in cycle N affects `req` from cycle N+1.
  - `mfc0` in cycle N returns the pre-write value of a register being written in cycle N; there is no internal bypass.
- Cause.IP read by `mfc0` lags `hw_int` by one cycle.
- The `epc` output reflects the EPC value written at the previous edge. `eret` in the cycle after an exception sees the new EPC.
- No stall input: the pipeline must hold M-stage signals invalid (`exc_valid_m`=0, `cp0_we`=0, `eret_m`=0) during stalls or bubbles.
  - Interrupts may still be taken on a bubble; EPC then takes the bubble's `pc_m`. The pipeline must therefore keep a valid `pc_m` in bubbles.

## Structure
- Shared package `cp0_pkg`:
  - Register indices 12–15.
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - SR/Cause field bit positions.
  - `HANDLER_PC`.
- One sub-module, `cp0_exc_arbiter`:
  - Combinational.
  - Inputs: IP, IM, IE, EXL, `exc_valid_m`, `exc_code_m`.
  - Outputs: `req`, the selected ExcCode.
  - The register file and write-precedence logic stay in `cp0`.

## Test plan
- **Reset then exception:** reset; `exc_valid_m`=1, `exc_code_m`=12, `pc_m`=32'h3010, `bd_m`=0 → `req`=1 that cycle. Next cycle:
  - EPC=32'h3010, ExcCode=12, EXL=1.
  - `req`=0 while `exc_valid_m` stays 1.
- **Delay slot:** `bd_m`=1, `pc_m`=32'h3024, AdEL → EPC=32'h3020, Cause.BD=1, ExcCode=4.
- **Interrupt enable:** `mtc0` SR=32'h0000_0401 (IM0, IE); `hw_int`=6'b000001 → `req`=1 from the cycle after the write. ExcCode=0.
  - Same sequence with IM=0 → `req` stays 0, while Cause.IP[10] reads 1 one cycle after `hw_int` rises.
- **Simultaneous interrupt and exception:** `int_pend` and RI in the same cycle → ExcCode=0. The `mtc0` EPC=32'h1234 issued in that cycle is ignored.
- **`eret` and EXL:** EXL=1, `eret_m`=1 → EXL=0 next cycle; `epc` output unchanged. With `eret_m` and `mtc0` SR=32'h2 in the same cycle → EXL=0.
- **Reset mid-handler:** EXL=1, EPC≠0, assert `reset` with `exc_valid_m`=1 → SR=Cause=EPC=0 next cycle.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, ExcCodes, SR/Cause field positions and the exception vector.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 10;
  localparam int SR_IM_HI    = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_exc_arbiter.sv
// Combinational interrupt-vs-exception arbiter; zero latency, no backpressure.
// Interrupts win over a same-cycle exception; EXL masks both.
module cp0_exc_arbiter
  import cp0_pkg::*;
(
  input  logic [5:0] ip,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic       exc_valid_m,
  input  logic [4:0] exc_code_m,
  output logic       req,
  output logic [4:0] exc_code_sel
);

  logic int_pend;
  logic exc_take;

  always_comb begin
    int_pend     = (|(ip & im)) & ie & ~exl;
    exc_take     = exc_valid_m & ~exl;
    req          = int_pend | exc_take;
    exc_code_sel = int_pend ? EXC_INT : exc_code_m;
  end

endmodule

// File: rtl/cp0.sv
// MIPS32 coprocessor 0 (SR, Cause, EPC, PRId) beside the M stage; req/rdata are combinational,
// state lands on the next edge. No stall input: the pipeline holds M-stage controls low in bubbles.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2019,
  parameter logic [31:0] HANDLER_PC = cp0_pkg::HANDLER_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic        exc_valid_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic        eret_m,
  output logic        req,
  output logic [31:0] epc
);

  // The vector is consumed by the PC mux; it must at least be word aligned.
  if (HANDLER_PC[1:0] != 2'b00) begin : g_bad_vector
    $error("cp0: HANDLER_PC must be word aligned");
  end

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [29:0] epc_q, epc_d;

  logic [4:0]  exc_code_sel;
  logic [29:0] epc_word;
  logic        pc_unused;

  assign pc_unused = ^pc_m[1:0];

  cp0_exc_arbiter u_arb (
    .ip           (hw_int),
    .im           (sr_im_q),
    .ie           (sr_ie_q),
    .exl          (sr_exl_q),
    .exc_valid_m  (exc_valid_m),
    .exc_code_m   (exc_code_m),
    .req          (req),
    .exc_code_sel (exc_code_sel)
  );

  // Delay-slot victims restart at the branch, one word back (modulo 2^32).
  assign epc_word = bd_m ? (pc_m[31:2] - 30'd1) : pc_m[31:2];

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;

    if (req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd_m;
      cause_exc_d = exc_code_sel;
      epc_d       = epc_word;
    end else begin
      if (cp0_we) begin
        case (cp0_addr)
          REG_SR: begin
            sr_im_d  = cp0_wdata[SR_IM_HI:SR_IM_LO];
            sr_exl_d = cp0_wdata[SR_EXL];
            sr_ie_d  = cp0_wdata[SR_IE];
          end
          REG_EPC: epc_d = cp0_wdata[31:2];
          default: ;
        endcase
      end
      // eret overrides only the EXL bit of a coincident SR write.
      if (eret_m) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      REG_SR: begin
        cp0_rdata[SR_IM_HI:SR_IM_LO] = sr_im_q;
        cp0_rdata[SR_EXL]            = sr_exl_q;
        cp0_rdata[SR_IE]             = sr_ie_q;
      end
      REG_CAUSE: begin
        cp0_rdata[CAUSE_BD]                   = cause_bd_q;
        cp0_rdata[CAUSE_IP_HI:CAUSE_IP_LO]    = cause_ip_q;
        cp0_rdata[CAUSE_EXC_HI:CAUSE_EXC_LO]  = cause_exc_q;
      end
      REG_EPC:  cp0_rdata = {epc_q, 2'b00};
      REG_PRID: cp0_rdata = PRID_VALUE;
      default:  cp0_rdata = '0;
    endcase
  end

  assign epc = {epc_q, 2'b00};

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: inputs change 1ns after the rising edge, outputs are checked before the next one.
module tb_cp0;
  import cp0_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_valid_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        eret_m;
  logic        req;
  logic [31:0] epc;

  int n_chk;
  int n_bad;

  cp0 dut (
    .clk         (clk),
    .reset       (reset),
    .pc_m        (pc_m),
    .bd_m        (bd_m),
    .exc_valid_m (exc_valid_m),
    .exc_code_m  (exc_code_m),
    .hw_int      (hw_int),
    .cp0_we      (cp0_we),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .cp0_rdata   (cp0_rdata),
    .eret_m      (eret_m),
    .req         (req),
    .epc         (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic idle();
    exc_valid_m = 1'b0;
    cp0_we      = 1'b0;
    eret_m      = 1'b0;
    bd_m        = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    pc_m = 32'h0; bd_m = 1'b0; exc_valid_m = 1'b0; exc_code_m = 5'd0;
    hw_int = 6'h0; cp0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'h0; eret_m = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state: IE=0 masks every interrupt line.
    hw_int = 6'h3f;
    #1 chk("rst_req_masked", {31'd0, req}, 32'd0);
    rd("rst_sr", REG_SR, 32'h0);
    rd("rst_cause", REG_CAUSE, 32'h0);
    rd("rst_epc", REG_EPC, 32'h0);
    rd("prid", REG_PRID, 32'h0000_2019);
    rd("other_idx", 5'd3, 32'h0);
    step();
    hw_int = 6'h0;

    // Overflow exception, not in a delay slot.
    exc_valid_m = 1'b1; exc_code_m = EXC_OV; pc_m = 32'h3010; bd_m = 1'b0;
    #1 chk("ov_req", {31'd0, req}, 32'd1);
    step();
    chk("ov_epc", epc, 32'h3010);
    rd("ov_cause", REG_CAUSE, 32'h0000_0030);
    rd("ov_sr_exl", REG_SR, 32'h0000_0002);
    chk("ov_req_exl_mask", {31'd0, req}, 32'd0);
    exc_valid_m = 1'b0;

    // eret clears EXL and leaves EPC alone.
    eret_m = 1'b1;
    step();
    eret_m = 1'b0;
    rd("eret_sr", REG_SR, 32'h0);
    chk("eret_epc", epc, 32'h3010);

    // AdEL in a delay slot.
    exc_valid_m = 1'b1; exc_code_m = EXC_ADEL; pc_m = 32'h3024; bd_m = 1'b1;
    step();
    idle();
    chk("bd_epc", epc, 32'h3020);
    rd("bd_cause", REG_CAUSE, 32'h8000_0010);

    // eret coinciding with an mtc0 SR that would set EXL.
    eret_m = 1'b1; cp0_we = 1'b1; cp0_addr = REG_SR; cp0_wdata = 32'h2;
    step();
    idle();
    rd("eret_vs_mtc0", REG_SR, 32'h0);
    chk("eret_mtc0_epc", epc, 32'h3020);

    // Enable IM0 + IE: the interrupt is seen only from the cycle after the write.
    cp0_we = 1'b1; cp0_addr = REG_SR; cp0_wdata = 32'h0000_0401; hw_int = 6'b000001;
    #1 chk("int_req_before", {31'd0, req}, 32'd0);
    step();
    cp0_we = 1'b0; pc_m = 32'h3030;
    #1 chk("int_req_after", {31'd0, req}, 32'd1);
    rd("int_sr", REG_SR, 32'h0000_0401);
    step();
    rd("int_cause", REG_CAUSE, 32'h0000_0400);
    chk("int_epc", epc, 32'h3030);
    rd("int_sr_exl", REG_SR, 32'h0000_0403);

    // IM=0: no request, IP still tracks hw_int one cycle late.
    cp0_we = 1'b1; cp0_addr = REG_SR; cp0_wdata = 32'h0000_0001; hw_int = 6'h0;
    step();
    cp0_we = 1'b0; hw_int = 6'b000001;
    rd("ip_lag", REG_CAUSE, 32'h0);
    chk("im0_req", {31'd0, req}, 32'd0);
    step();
    rd("ip_seen", REG_CAUSE, 32'h0000_0400);
    chk("im0_req_next", {31'd0, req}, 32'd0);

    // Interrupt and RI together, with an mtc0 EPC that must be dropped.
    cp0_we = 1'b1; cp0_addr = REG_SR; cp0_wdata = 32'h0000_0401;
    step();
    exc_valid_m = 1'b1; exc_code_m = EXC_RI; pc_m = 32'h3040;
    cp0_we = 1'b1; cp0_addr = REG_EPC; cp0_wdata = 32'h1234;
    #1 chk("both_req", {31'd0, req}, 32'd1);
    step();
    idle();
    rd("both_cause", REG_CAUSE, 32'h0000_0400);
    chk("both_epc", epc, 32'h3040);

    // Reset mid-handler overrides a pending exception.
    reset = 1'b1; exc_valid_m = 1'b1;
    step();
    reset = 1'b0; exc_valid_m = 1'b0;
    rd("rst2_sr", REG_SR, 32'h0);
    rd("rst2_cause", REG_CAUSE, 32'h0);
    chk("rst2_epc", epc, 32'h0);
    chk("rst2_req_int", {31'd0, req}, 32'd0);
    exc_valid_m = 1'b1; exc_code_m = EXC_ADES; bd_m = 1'b1; pc_m = 32'h0;
    #1 chk("rst2_req_exc", {31'd0, req}, 32'd1);

    // pc_m-4 wraps from 0.
    step();
    idle();
    chk("wrap_epc", epc, 32'hFFFF_FFFC);
    rd("wrap_cause", REG_CAUSE, 32'h8000_0414);

    // mtc0 EPC: same-cycle mfc0 sees the old value, low bits never stored.
    eret_m = 1'b1;
    step();
    eret_m = 1'b0;
    cp0_we = 1'b1; cp0_addr = REG_EPC; cp0_wdata = 32'h0000_5557;
    rd("epc_no_bypass", REG_EPC, 32'hFFFF_FFFC);
    step();
    cp0_we = 1'b0;
    rd("epc_write", REG_EPC, 32'h0000_5554);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
